sensor_height_sampler: RTL and testbench

- Upstream acquisition stage for square_root: samples four 8-bit distance sensors, rejects invalid sensor pairs, and averages 2^NSAMP_LOG2 accepted samples over time.
- Emits one rounded 8-bit height value per window; height feeds square_root's `in` directly.
- Valid/ready handshake on both sides; holds its result until the downstream register accepts it.

---
 rtl/sensor_height_sampler.sv | 171 +++++++++++++++++
 tb/tb_sensor_height_sampler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_height_sampler.sv
`default_nettype none
// ============================================================================
// Module   : sensor_height_sampler
// Purpose  : Samples four 8-bit distance sensors and rejects sensor pairs
//            that read zero. It averages 2**NSAMP_LOG2 accepted samples and
//            emits one rounded 8-bit height per window.
// Ports    : clk, rst (async, active-high)
//            sample_valid / sample_ready  - upstream handshake
//            sensor1..sensor4             - unsigned sensor readings
//            height / height_valid        - registered result, held until
//            height_ready                   accepted by downstream
//            err_zero                     - 1-cycle pulse, sample discarded
// Revision : 1.0 - initial release
// ============================================================================
module sensor_height_sampler #(
    parameter int NSAMP_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic [7:0] sensor1,
    input  logic [7:0] sensor2,
    input  logic [7:0] sensor3,
    input  logic [7:0] sensor4,
    output logic [7:0] height,
    output logic       height_valid,
    input  logic       height_ready,
    output logic       err_zero
);

    localparam int c_AW = 8 + NSAMP_LOG2;
    // A zero-width counter is not legal, so keep at least one bit. With
    // NSAMP_LOG2 == 0 every good sample is the last one and cnt stays 0.
    localparam int c_CW = (NSAMP_LOG2 == 0) ? 1 : NSAMP_LOG2;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'((1 << NSAMP_LOG2) - 1);
    // Half an LSB of the divided result. This evaluates to 0 when no shift is applied.
    localparam logic [c_AW:0]   c_HALF     = (c_AW + 1)'((1 << NSAMP_LOG2) >> 1);

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_DIV = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_AW-1:0]   r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic [7:0]        r_height;
    logic              r_hvalid;
    logic              r_ready;
    logic              r_err;

    logic              w_ok13;
    logic              w_ok24;
    logic [9:0]        w_sum13;
    logic [9:0]        w_sum24;
    logic [7:0]        w_avg4;
    logic [7:0]        w_avg13;
    logic [7:0]        w_avg24;
    logic [7:0]        w_v;
    logic              w_take;
    logic              w_discard;
    logic              w_good;
    logic              w_last;
    logic [c_AW:0]     w_round;
    logic [c_AW:0]     w_quot;
    logic [7:0]        w_height;

    // ------------------------------------------------------------------
    // Per-sample value. Sums are formed at 10 bits so that the rounding
    // constant cannot overflow before the shift.
    // ------------------------------------------------------------------
    assign w_ok13  = (sensor1 != 8'd0) && (sensor3 != 8'd0);
    assign w_ok24  = (sensor2 != 8'd0) && (sensor4 != 8'd0);
    assign w_sum13 = {2'b00, sensor1} + {2'b00, sensor3};
    assign w_sum24 = {2'b00, sensor2} + {2'b00, sensor4};
    assign w_avg4  = 8'((w_sum13 + w_sum24 + 10'd2) >> 2);
    assign w_avg13 = 8'((w_sum13 + 10'd1) >> 1);
    assign w_avg24 = 8'((w_sum24 + 10'd1) >> 1);

    always_comb begin
        w_v = 8'd0;
        case ({w_ok13, w_ok24})
            2'b11:   w_v = w_avg4;
            2'b01:   w_v = w_avg24;
            2'b10:   w_v = w_avg13;
            default: w_v = 8'd0;
        endcase
    end

    // r_ready is registered from next state, so it is high only in ACC.
    assign w_take    = sample_valid && r_ready;
    assign w_discard = w_take && !w_ok13 && !w_ok24;
    assign w_good    = w_take && !w_discard;
    assign w_last    = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // Rounded division by the window size. The saturation clamp is kept
    // even though the average of 8-bit values cannot exceed 255.
    // ------------------------------------------------------------------
    assign w_round  = {1'b0, r_acc} + c_HALF;
    assign w_quot   = w_round >> NSAMP_LOG2;
    assign w_height = (|w_quot[c_AW:8]) ? 8'hFF : w_quot[7:0];

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:  if (w_good && w_last) w_state_nxt = ST_DIV;
            ST_DIV:  w_state_nxt = ST_OUT;
            ST_OUT:  if (height_ready) w_state_nxt = ST_ACC;
            default: w_state_nxt = ST_ACC;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_height <= 8'd0;
            r_hvalid <= 1'b0;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == ST_ACC);
            r_err   <= w_discard;
            case (r_state)
                ST_ACC: begin
                    if (w_good) begin
                        r_acc <= r_acc + c_AW'(w_v);
                        r_cnt <= w_last ? '0 : r_cnt + c_CW'(1);
                    end
                end
                ST_DIV: begin
                    r_height <= w_height;
                    r_hvalid <= 1'b1;
                end
                ST_OUT: begin
                    if (height_ready) begin
                        r_hvalid <= 1'b0;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sample_ready = r_ready;
    assign height       = r_height;
    assign height_valid = r_hvalid;
    assign err_zero     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sensor_height_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_height_sampler
// Purpose  : Self-checking bench for sensor_height_sampler. The reference
//            model keeps a running sum and count of accepted sample values.
//            These values are derived from the pair rules with integer
//            arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_height_sampler;

    localparam int LOG2 = 2;
    localparam int NS   = 1 << LOG2;

    logic       clk;
    logic       rst;
    logic       sample_valid;
    logic       sample_ready;
    logic [7:0] sensor1;
    logic [7:0] sensor2;
    logic [7:0] sensor3;
    logic [7:0] sensor4;
    logic [7:0] height;
    logic       height_valid;
    logic       height_ready;
    logic       err_zero;

    int checks = 0;
    int errors = 0;

    // reference model state
    int q_sum    = 0;
    int q_n      = 0;
    int hold_n   = 0;
    bit hr_flag  = 0;
    bit skip_ack = 0;

    sensor_height_sampler #(.NSAMP_LOG2(LOG2)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sensor1      (sensor1),
        .sensor2      (sensor2),
        .sensor3      (sensor3),
        .sensor4      (sensor4),
        .height       (height),
        .height_valid (height_valid),
        .height_ready (height_ready),
        .err_zero     (err_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns -1 for a discarded sample, otherwise the 8-bit sample value.
    function automatic int model_v(input int a, input int b, input int c, input int d);
        bit ok13;
        bit ok24;
        ok13 = (a != 0) && (c != 0);
        ok24 = (b != 0) && (d != 0);
        if (ok13 && ok24) return (a + b + c + d + 2) / 4;
        if (ok24)         return (b + d + 1) / 2;
        if (ok13)         return (a + c + 1) / 2;
        return -1;
    endfunction

    task automatic complete_window();
        int exp_h;
        exp_h = (q_sum + NS / 2) / NS;
        if (exp_h > 255) exp_h = 255;
        // now in DIV: height_ready here must be ignored
        chk("div_ready_low", sample_ready, 0);
        chk("div_valid_low", height_valid, 0);
        height_ready = hr_flag;
        step();
        height_ready = 1'b0;
        chk("out_valid", height_valid, 1);
        chk("out_height", height, exp_h);
        chk("out_ready_low", sample_ready, 0);
        q_sum = 0;
        q_n   = 0;
        if (skip_ack) return;
        for (int h = 0; h < hold_n; h++) begin
            sample_valid = 1'b1;
            sensor1 = 8'($urandom_range(1, 255));
            sensor2 = 8'($urandom_range(1, 255));
            sensor3 = 8'($urandom_range(1, 255));
            sensor4 = 8'($urandom_range(1, 255));
            step();
            chk("hold_height", height, exp_h);
            chk("hold_valid", height_valid, 1);
            chk("hold_ready_low", sample_ready, 0);
        end
        sample_valid = 1'b0;
        height_ready = 1'b1;
        step();
        height_ready = 1'b0;
        chk("ack_valid_low", height_valid, 0);
        chk("ack_height_kept", height, exp_h);
        chk("ack_ready_high", sample_ready, 1);
    endtask

    task automatic send(input int a, input int b, input int c, input int d);
        int v;
        int n;
        bit got;
        sample_valid = 1'b1;
        sensor1 = 8'(a);
        sensor2 = 8'(b);
        sensor3 = 8'(c);
        sensor4 = 8'(d);
        height_ready = hr_flag;   // ignored while accumulating
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            if (sample_ready === 1'b1) got = 1'b1;
            else begin
                step();
                n++;
            end
        end
        chk("accept_in_time", got, 1);
        if (!got) begin
            sample_valid = 1'b0;
            height_ready = 1'b0;
            return;
        end
        step();
        sample_valid = 1'b0;
        height_ready = 1'b0;
        v = model_v(a, b, c, d);
        if (v < 0) begin
            chk("err_zero_pulse", err_zero, 1);
            step();
            chk("err_zero_one_cycle", err_zero, 0);
        end else begin
            chk("err_zero_quiet", err_zero, 0);
            q_sum += v;
            q_n++;
            if (q_n == NS) complete_window();
        end
    endtask

    task automatic send_rand();
        int s[4];
        for (int i = 0; i < 4; i++)
            s[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
        send(s[0], s[1], s[2], s[3]);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset_midcycle();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_height", height, 0);
        chk("rst_valid", height_valid, 0);
        chk("rst_ready", sample_ready, 0);
        chk("rst_err", err_zero, 0);
        q_sum = 0;
        q_n   = 0;
        step();
        rst = 1'b0;
        chk("rel_ready_low", sample_ready, 0);
        step();
        chk("rel_ready_high", sample_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        height_ready = 1'b0;
        sensor1 = 8'd0;
        sensor2 = 8'd0;
        sensor3 = 8'd0;
        sensor4 = 8'd0;

        // reset state
        step();
        step();
        chk("reset_height", height, 0);
        chk("reset_valid", height_valid, 0);
        chk("reset_ready", sample_ready, 0);
        chk("reset_err", err_zero, 0);
        rst = 1'b0;
        chk("release_ready_low", sample_ready, 0);
        step();
        chk("first_edge_ready", sample_ready, 1);

        // basic window: v=25 each
        repeat (NS) send(10, 20, 30, 40);

        // pair rule mix, height_ready high during ACC/DIV is ignored
        hr_flag = 1'b1;
        send(0, 11, 50, 20);
        send(12, 0, 7, 9);
        send(10, 20, 30, 40);
        send(255, 255, 255, 255);
        hr_flag = 1'b0;

        // discards, including one in the final slot
        send(10, 20, 30, 40);
        send(0, 0, 5, 5);
        send(20, 20, 20, 20);
        send(30, 30, 30, 30);
        send(5, 0, 0, 5);
        chk("discard_no_complete_valid", height_valid, 0);
        chk("discard_no_complete_ready", sample_ready, 1);
        send(40, 40, 40, 40);

        // extremes
        repeat (NS) send(255, 255, 255, 255);
        repeat (NS) send(1, 1, 1, 1);

        // backpressure in OUT
        hold_n = 5;
        repeat (NS) send(50, 60, 70, 80);
        hold_n = 0;

        // reset mid-window, then a clean window
        send(100, 100, 100, 100);
        send(100, 100, 100, 100);
        do_reset_midcycle();
        repeat (NS) send(8, 8, 8, 8);

        // reset while holding a result in OUT
        skip_ack = 1'b1;
        repeat (NS) send(90, 91, 92, 93);
        skip_ack = 1'b0;
        do_reset_midcycle();

        // randomized windows
        for (int w = 0; w < 10; w++) begin
            int guard;
            hold_n  = int'($urandom_range(0, 3));
            hr_flag = 1'($urandom_range(0, 1));
            guard = 0;
            do begin
                send_rand();
                guard++;
            end while (q_n != 0 && guard < 100);
        end
        hr_flag = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
